jtag_bus_bridge: RTL and testbench

JTAG data-register stage and system-bus master that sits directly downstream of the JTAG address/control user register. It consumes that register's ADDR, WR and INC outputs and provides a second BSCAN user data register. A scanned UPDATE launches a single bus read or write in the CLK domain, and read data and status come back on the next CAPTURE. All TCK↔CLK crossings use toggle handshakes with held-stable payload registers.

---
 rtl/jtag_bridge_pkg.sv | 25 ++
 rtl/jtag_bus_bridge_if.sv | 28 ++
 rtl/jtag_tgl_sync.sv | 28 ++
 rtl/jtag_bus_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_jtag_bus_bridge.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_bridge_pkg.sv
// Shared types and defaults for the JTAG data-register bus bridge.
package jtag_bridge_pkg;

    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR,
        StDone
    } bridge_state_e;

    // Status bits sit directly above the data word in the scan register.
    function automatic int unsigned err_bit(int unsigned data_w);
        return data_w + 1;
    endfunction

    function automatic int unsigned busy_bit(int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/jtag_bus_bridge_if.sv
// System-bus side of the JTAG bridge: single-beat request/grant plus read-valid return.
interface jtag_bus_bridge_if
    import jtag_bridge_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic                req_o;
    logic                we_o;
    logic [ADDR_W-1:0]   addr_o;
    logic [DATA_W-1:0]   wdata_o;
    logic [DATA_W/8-1:0] be_o;
    logic                gnt_i;
    logic                rvalid_i;
    logic [DATA_W-1:0]   rdata_i;

    modport master (
        output req_o, we_o, addr_o, wdata_o, be_o,
        input  gnt_i, rvalid_i, rdata_i
    );

    modport slave (
        input  req_o, we_o, addr_o, wdata_o, be_o,
        output gnt_i, rvalid_i, rdata_i
    );

endinterface

// File: rtl/jtag_tgl_sync.sv
// Toggle synchronizer: SYNC_STAGES flops into the destination clock plus a one-cycle edge pulse.
module jtag_tgl_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic tgl_i,
    output logic tgl_o,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tgl_o   = sync_q[SYNC_STAGES-1];
    assign pulse_o = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/jtag_bus_bridge.sv
// JTAG user data register that launches single bus accesses in the CLK domain.
// Optional abort-on-timeout is built when JTAG_BRIDGE_TIMEOUT_EN is defined.
module jtag_bus_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              TCK,
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SEL,
    input  logic              CAPTURE,
    input  logic              SHIFT,
    input  logic              UPDATE,
    input  logic              TDI,
    output logic              TDO,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              WR,
    input  logic              INC,
    output logic              BUSY,
    output logic              ERR,
    jtag_bus_bridge_if.master bus
);

    localparam int unsigned       SR_W     = DATA_W + 2;
    localparam int unsigned       ERR_BIT  = err_bit(DATA_W);
    localparam int unsigned       BUSY_BIT = busy_bit(DATA_W);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(DATA_W / 8);

    // TCK domain
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] addr_h_q, addr_h_d;
    logic              we_h_q, we_h_d;
    logic [DATA_W-1:0] wdata_h_q, wdata_h_d;
    logic              req_tgl_q, req_tgl_d;
    logic              ack_sync, ack_pulse;

    // CLK domain
    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_c_q, err_c_d;
    logic              ack_tgl_q, ack_tgl_d;
    logic              req_pulse;
    logic              unused_req_lvl;

    jtag_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i   (CLK),
        .reset_i (RESET),
        .tgl_i   (req_tgl_q),
        .tgl_o   (unused_req_lvl),
        .pulse_o (req_pulse)
    );

    jtag_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i   (TCK),
        .reset_i (RESET),
        .tgl_i   (ack_tgl_q),
        .tgl_o   (ack_sync),
        .pulse_o (ack_pulse)
    );

    assign BUSY = req_tgl_q ^ ack_sync;
    assign ERR  = err_q;
    assign TDO  = sr_q[0];

    always_comb begin
        sr_d      = sr_q;
        err_d     = err_q;
        base_d    = base_q;
        offset_d  = offset_q;
        addr_h_d  = addr_h_q;
        we_h_d    = we_h_q;
        wdata_h_d = wdata_h_q;
        req_tgl_d = req_tgl_q;

        // Completion bookkeeping first so a launch on the same edge sees the bumped offset.
        if (ack_pulse) begin
            err_d = err_q | err_c_q;
            if (INC) begin
                offset_d = offset_q + STEP;
            end
        end

        if (SEL) begin
            if (CAPTURE) begin
                sr_d = {err_q, BUSY, rdata_q};
            end
            if (UPDATE) begin
                if (sr_d[ERR_BIT]) begin
                    err_d = 1'b0;
                end else if (!sr_d[BUSY_BIT]) begin
                    if (BUSY) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_h_d = sr_d[DATA_W-1:0];
                        we_h_d    = WR;
                        if (ADDR != base_q || !INC) begin
                            base_d   = ADDR;
                            offset_d = '0;
                            addr_h_d = ADDR;
                        end else begin
                            addr_h_d = base_q + offset_d;
                        end
                        req_tgl_d = ~req_tgl_q;
                    end
                end
            end
            if (SHIFT) begin
                sr_d = {TDI, sr_d[SR_W-1:1]};
            end
        end
    end

    always_ff @(posedge TCK) begin
        if (RESET) begin
            sr_q      <= '0;
            err_q     <= 1'b0;
            base_q    <= '0;
            offset_q  <= '0;
            addr_h_q  <= '0;
            we_h_q    <= 1'b0;
            wdata_h_q <= '0;
            req_tgl_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            err_q     <= err_d;
            base_q    <= base_d;
            offset_q  <= offset_d;
            addr_h_q  <= addr_h_d;
            we_h_q    <= we_h_d;
            wdata_h_q <= wdata_h_d;
            req_tgl_q <= req_tgl_d;
        end
    end

`ifdef JTAG_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_c_d   = err_c_q;
        ack_tgl_d = ack_tgl_q;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_pulse) begin
                    addr_d  = addr_h_q;
                    we_d    = we_h_q;
                    wdata_d = wdata_h_q;
                    err_c_d = 1'b0;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.gnt_i) begin
                    state_d = we_q ? StDone : StWaitR;
                end
            end
            StWaitR: begin
                if (bus.rvalid_i) begin
                    rdata_d = bus.rdata_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                ack_tgl_d = ~ack_tgl_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
`ifdef JTAG_BRIDGE_TIMEOUT_EN
        // A grant or read data arriving in the final cycle still wins over the abort.
        if (state_q == StReq || state_q == StWaitR) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TMO_LAST && state_d == state_q) begin
                err_c_d = 1'b1;
                state_d = StDone;
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_c_q   <= 1'b0;
            ack_tgl_q <= 1'b0;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_c_q   <= err_c_d;
            ack_tgl_q <= ack_tgl_d;
`ifdef JTAG_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.req_o   = (state_q == StReq);
    assign bus.we_o    = we_q;
    assign bus.addr_o  = addr_q;
    assign bus.wdata_o = wdata_q;
    assign bus.be_o    = '1;

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Directed bench for jtag_bus_bridge: scan tasks drive the BSCAN port, a bus responder
// records accepted beats, and expected beats are queued as each access is launched.
module tb_jtag_bus_bridge;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 32;
    localparam int unsigned SRW = DW + 2;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } beat_t;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] be;
    } obs_t;

    logic          TCK = 1'b0;
    logic          CLK = 1'b0;
    logic          RESET;
    logic          SEL, CAPTURE, SHIFT, UPDATE, TDI;
    logic          TDO;
    logic [AW-1:0] ADDR;
    logic          WR, INC;
    logic          BUSY, ERR;

    jtag_bus_bridge_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    jtag_bus_bridge #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .TCK     (TCK),
        .CLK     (CLK),
        .RESET   (RESET),
        .SEL     (SEL),
        .CAPTURE (CAPTURE),
        .SHIFT   (SHIFT),
        .UPDATE  (UPDATE),
        .TDI     (TDI),
        .TDO     (TDO),
        .ADDR    (ADDR),
        .WR      (WR),
        .INC     (INC),
        .BUSY    (BUSY),
        .ERR     (ERR),
        .bus     (bus)
    );

    always #10 TCK = ~TCK;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t sb[$];
    obs_t  obs[$];
    int    obs_rd = 0;

    // Responder controls, written only by the stimulus block.
    logic          gnt_en = 1'b1;
    int            gnt_delay = 0;
    logic          rvalid_en = 1'b1;
    logic [DW-1:0] rd_data = '0;
    int            stray_cnt = 0;

    int req_cycles = 0;
    int rd_wait    = -1;
    int stray_done = 0;

    always @(negedge CLK) begin
        bus.gnt_i    = 1'b0;
        bus.rvalid_i = 1'b0;
        if (RESET) begin
            req_cycles = 0;
            rd_wait    = -1;
            bus.rdata_i = '0;
        end else begin
            if (bus.req_o) begin
                if (gnt_en && req_cycles >= gnt_delay) bus.gnt_i = 1'b1;
                req_cycles++;
            end else begin
                req_cycles = 0;
            end
            if (bus.req_o && bus.gnt_i) begin
                obs.push_back('{bus.we_o, bus.addr_o, bus.wdata_o, bus.be_o});
                if (!bus.we_o) rd_wait = 2;
            end else if (rd_wait > 0) begin
                rd_wait--;
            end else if (rd_wait == 0 && rvalid_en) begin
                bus.rvalid_i = 1'b1;
                bus.rdata_i  = rd_data;
                rd_wait      = -1;
            end
            if (stray_cnt != stray_done && !bus.rvalid_i) begin
                bus.rvalid_i = 1'b1;
                bus.rdata_i  = 64'h0000_0BAD_0BAD_0BAD;
                stray_done++;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic scan(input logic sel, input logic [SRW-1:0] din,
                        output logic [SRW-1:0] dout);
        @(negedge TCK);
        SEL     = sel;
        CAPTURE = 1'b1;
        @(negedge TCK);
        CAPTURE = 1'b0;
        SHIFT   = 1'b1;
        for (int i = 0; i < SRW; i++) begin
            dout[i] = TDO;
            TDI     = din[i];
            @(negedge TCK);
        end
        SHIFT  = 1'b0;
        UPDATE = 1'b1;
        @(negedge TCK);
        UPDATE = 1'b0;
        SEL    = 1'b0;
    endtask

    task automatic launch(input logic we, input logic [AW-1:0] adr, input logic inc,
                          input logic [DW-1:0] data, input logic [AW-1:0] exp_addr,
                          input logic push);
        logic [SRW-1:0] d;
        WR   = we;
        ADDR = adr;
        INC  = inc;
        if (push) sb.push_back('{we, exp_addr, data});
        scan(1'b1, {2'b00, data}, d);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (BUSY && n < 400) begin
            @(negedge TCK);
            n++;
        end
        @(negedge TCK);
        check(tag, BUSY, 0);
    endtask

    task automatic check_beats();
        beat_t e;
        while (obs_rd < obs.size()) begin
            check("beat_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("beat_we", obs[obs_rd].we, e.we);
                check("beat_addr", obs[obs_rd].addr, e.addr);
                check("beat_wdata", obs[obs_rd].wdata, e.wdata);
                check("beat_be", obs[obs_rd].be, 8'hFF);
            end
            obs_rd++;
        end
        check("beat_missing", sb.size(), 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (6) @(negedge TCK);
        RESET = 1'b0;
        @(negedge TCK);
    endtask

    logic [AW-1:0] inc_addr [3];
    logic [SRW-1:0] dout;
    int n;

    initial begin
        inc_addr[0] = 32'hFFFF_FFF8;
        inc_addr[1] = 32'h0000_0000;
        inc_addr[2] = 32'h0000_0008;
        SEL = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0;
        ADDR = '0; WR = 0; INC = 0;
        do_reset();

        check("rst_req", bus.req_o, 0);
        check("rst_we", bus.we_o, 0);
        check("rst_addr", bus.addr_o, 0);
        check("rst_wdata", bus.wdata_o, 0);
        check("rst_be", bus.be_o, 8'hFF);
        check("rst_busy", BUSY, 0);
        check("rst_err", ERR, 0);
        check("rst_tdo", TDO, 0);

        // Scan with SEL low must not launch anything.
        WR = 1; ADDR = 32'h1000; INC = 0;
        scan(1'b0, {2'b00, 64'h55}, dout);
        repeat (20) @(negedge CLK);
        check("sel0_busy", BUSY, 0);
        check_beats();

        gnt_delay = 3;
        launch(1, 32'h1000, 0, 64'hDEAD_BEEF_0000_0001, 32'h1000, 1);
        check("wr_busy", BUSY, 1);
        wait_idle("wr_idle");
        check_beats();
        check("wr_err", ERR, 0);

        gnt_delay = 1;
        rd_data   = 64'h1234;
        launch(0, 32'h3000, 0, 64'h0, 32'h3000, 1);
        wait_idle("rd_idle");
        check_beats();
        stray_cnt++;
        repeat (10) @(negedge CLK);
        scan(1'b1, {2'b01, 64'h0}, dout);
        check("rd_capture", dout, {2'b00, 64'h1234});
        check_beats();

        gnt_delay = 0;
        for (int i = 0; i < 3; i++) begin
            launch(1, 32'hFFFF_FFF8, 1, 64'hA0 + 64'(i), inc_addr[i], 1);
            wait_idle("inc_idle");
            check_beats();
        end
        launch(1, 32'h2000, 1, 64'hB0, 32'h2000, 1);
        wait_idle("inc_new_idle");
        launch(1, 32'h2000, 1, 64'hB1, 32'h2008, 1);
        wait_idle("inc_next_idle");
        check_beats();

        // Overrun: second UPDATE while the first access is stalled.
        gnt_en = 0;
        launch(1, 32'h4000, 0, 64'h1111, 32'h4000, 1);
        repeat (10) @(negedge CLK);
        check("ovr_req", bus.req_o, 1);
        launch(1, 32'h4000, 0, 64'h2222, 32'h4000, 0);
        check("ovr_err", ERR, 1);
        check("ovr_busy", BUSY, 1);
        gnt_en = 1;
        wait_idle("ovr_idle");
        check_beats();
        check("ovr_err_sticky", ERR, 1);
        scan(1'b1, {2'b10, 64'h0}, dout);
        check("clr_capture_err", dout[SRW-1], 1);
        check("clr_err", ERR, 0);
        check("clr_busy", BUSY, 0);
        check_beats();

        // Never-granted access.
        gnt_en = 0;
        launch(1, 32'h5000, 0, 64'h5555, 32'h5000, 0);
        n = 0;
        while (!bus.req_o && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("tmo_req_rise", bus.req_o, 1);
`ifdef JTAG_BRIDGE_TIMEOUT_EN
        n = 0;
        while (bus.req_o && n < 1100) begin
            n++;
            @(negedge CLK);
        end
        check("tmo_len", n, 255);
        wait_idle("tmo_idle");
        check("tmo_err", ERR, 1);
        scan(1'b1, {2'b10, 64'h0}, dout);
        check("tmo_clr_err", ERR, 0);
`else
        repeat (1000) @(negedge CLK);
        check("no_tmo_req", bus.req_o, 1);
        check("no_tmo_busy", BUSY, 1);
        do_reset();
        check("no_tmo_rst_req", bus.req_o, 0);
        check("no_tmo_rst_busy", BUSY, 0);
`endif
        gnt_en = 1;
        check_beats();

        // Reset while waiting for read data.
        rvalid_en = 0;
        n = obs.size();
        launch(0, 32'h6000, 0, 64'h0, 32'h6000, 1);
        for (int k = 0; k < 200 && obs.size() == n; k++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        check("waitr_req", bus.req_o, 0);
        check("waitr_busy", BUSY, 1);
        do_reset();
        check("waitr_rst_req", bus.req_o, 0);
        check("waitr_rst_busy", BUSY, 0);
        check("waitr_rst_err", ERR, 0);
        check_beats();
        rvalid_en = 1;
        rd_data   = 64'hCAFE_F00D_0000_CAFE;
        launch(0, 32'h7000, 0, 64'h0, 32'h7000, 1);
        wait_idle("post_rst_idle");
        check_beats();
        scan(1'b1, {2'b01, 64'h0}, dout);
        check("post_rst_capture", dout, {2'b00, 64'hCAFE_F00D_0000_CAFE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
